// File: rtl/not_4.sv
// not_4 -- dual-lane bitwise inverter with optional registered copies and
// change tracking.
//
// Ports:
//   clk      in   rising-edge clock for the optional registered stage
//   rst_n    in   asynchronous active-low reset (registered stage only)
//   a, b     in   lane operands, WIDTH bits each
//   x, y     out  combinational ~a / ~b, unaffected by reset
//   x_q, y_q out  registered copies of x / y (1-cycle latency)
//   chg      out  registered pulse: the last capture changed {x_q,y_q}
//   chg_cnt  out  saturating count of chg pulses since reset (8 bits)
//
// Configuration macro: NOT_4_REG_EN
//   defined   -> registered stage, change pulse and counter are built
//   undefined -> x_q/y_q pass x/y through combinationally, chg and chg_cnt
//                are tied to zero, and no flops are inferred
module not_4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] x_q,
  output logic [WIDTH-1:0] y_q,
  output logic             chg,
  output logic [7:0]       chg_cnt
);

  // Plain inversion keeps X/Z on an input bit visible as X on the output.
  assign x = ~a;
  assign y = ~b;

`ifdef NOT_4_REG_EN

  logic       differs;
  logic [7:0] cnt_next;

  // One compare over both lanes, so simultaneous lane changes give one pulse.
  always_comb begin
    differs  = ({x, y} != {x_q, y_q});
    cnt_next = chg_cnt;
    if (differs && (chg_cnt != '1)) begin
      cnt_next = chg_cnt + 8'd1;
    end
  end

  // The counter advances on the same edge that raises chg, so chg_cnt always
  // equals the number of pulses seen so far, including the current one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q     <= '0;
      y_q     <= '0;
      chg     <= 1'b0;
      chg_cnt <= '0;
    end else begin
      x_q     <= x;
      y_q     <= y;
      chg     <= differs;
      chg_cnt <= cnt_next;
    end
  end

`else

  assign x_q     = x;
  assign y_q     = y;
  assign chg     = 1'b0;
  assign chg_cnt = '0;

  // clk and rst_n stay on the port list for drop-in compatibility.
  logic unused_clk_rst;
  assign unused_clk_rst = &{1'b0, clk, rst_n};

`endif

endmodule

// File: tb/tb_not_4.sv
// Self-checking bench for not_4. Stimulus drives inputs shortly after each
// rising edge and pushes the expected output set into a queue; a monitor
// pops and compares one entry at every falling edge.
module tb_not_4;

  logic       clk;
  logic       rst_n;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] x;
  logic [3:0] y;
  logic [3:0] x_q;
  logic [3:0] y_q;
  logic       chg;
  logic [7:0] chg_cnt;

  not_4 #(.WIDTH(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a),
    .b       (b),
    .x       (x),
    .y       (y),
    .x_q     (x_q),
    .y_q     (y_q),
    .chg     (chg),
    .chg_cnt (chg_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] ex;
    logic [3:0] ey;
    logic [3:0] exq;
    logic [3:0] eyq;
    logic       echg;
    logic [7:0] ecnt;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference state: what the registered side should hold, in plain numbers.
  int m_xq  = 0;
  int m_yq  = 0;
  int m_chg = 0;
  int m_cnt = 0;

  function automatic int inv4(input int v);
    return 15 - v;
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask

  // Monitor: one expected entry is consumed per falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("x",       int'(x),       int'(e.ex));
        check("y",       int'(y),       int'(e.ey));
        check("x_q",     int'(x_q),     int'(e.exq));
        check("y_q",     int'(y_q),     int'(e.eyq));
        check("chg",     int'(chg),     int'(e.echg));
        check("chg_cnt", int'(chg_cnt), int'(e.ecnt));
      end
    end
  end

  // One stimulus step per clock: advance the reference at the edge, then
  // apply new inputs / reset level and predict what the monitor should see.
  task automatic step(input logic [3:0] na, input logic [3:0] nb, input logic rst_lvl);
    exp_t e;
    int nx, ny;
    @(posedge clk);
`ifdef NOT_4_REG_EN
    if (rst_n) begin
      nx = inv4(int'(a));
      ny = inv4(int'(b));
      m_chg = (nx != m_xq || ny != m_yq) ? 1 : 0;
      if (m_chg == 1 && m_cnt < 255) m_cnt = m_cnt + 1;
      m_xq = nx;
      m_yq = ny;
    end
`endif
    #1;
    rst_n = rst_lvl;
    a = na;
    b = nb;
`ifdef NOT_4_REG_EN
    if (!rst_lvl) begin
      m_xq = 0; m_yq = 0; m_chg = 0; m_cnt = 0;
    end
`else
    m_xq = inv4(int'(na));
    m_yq = inv4(int'(nb));
    m_chg = 0;
    m_cnt = 0;
`endif
    e.ex   = 4'(inv4(int'(na)));
    e.ey   = 4'(inv4(int'(nb)));
    e.exq  = 4'(m_xq);
    e.eyq  = 4'(m_yq);
    e.echg = (m_chg != 0);
    e.ecnt = 8'(m_cnt);
    exp_q.push_back(e);
  endtask

  logic [3:0] pa [5] = '{4'b1010, 4'b1100, 4'b0001, 4'b0110, 4'b0101};
  logic [3:0] pb [5] = '{4'b0101, 4'b0011, 4'b1000, 4'b1001, 4'b0011};

  initial begin
    int wait_cycles;
    rst_n = 1'b0;
    a = 4'b0110;
    b = 4'b0000;
    #1;
    // Before any clock edge: inversion and pass-through/reset values.
    check("x_noclk", int'(x), 9);
    check("y_noclk", int'(y), 15);
`ifdef NOT_4_REG_EN
    check("x_q_noclk", int'(x_q), 0);
`else
    check("x_q_noclk", int'(x_q), 9);
`endif
    check("chg_noclk", int'(chg), 0);
    check("cnt_noclk", int'(chg_cnt), 0);

    step(4'b0000, 4'b0000, 1'b0);
    step(4'b1111, 4'b1111, 1'b1);
    step(4'b1111, 4'b1111, 1'b1);   // first capture equals reset value: no chg
    step(4'b0000, 4'b0000, 1'b1);
    step(4'b0000, 4'b0000, 1'b1);

    for (int i = 0; i < 5; i++) step(pa[i], pb[i], 1'b1);

    for (int i = 0; i < 256; i++) step(4'(i >> 4), 4'(i), 1'b1);

    for (int i = 0; i < 60; i++) step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b1);

    // Mid-run reset with a held at 1010, then release.
    step(4'b1010, 4'b0011, 1'b1);
    step(4'b1010, 4'b0011, 1'b1);
    step(4'b1010, 4'b0011, 1'b0);
    step(4'b1010, 4'b0011, 1'b1);
    step(4'b1010, 4'b0011, 1'b1);
    step(4'b1010, 4'b0011, 1'b1);

    // Toggle a every cycle long enough to saturate the counter.
    for (int i = 0; i < 300; i++) step((i % 2 == 0) ? 4'b0101 : 4'b1010, 4'b0011, 1'b1);

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0 entries left", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/not_4.md
NOT_4 -- requirements
Module: not_4

Interface
REQ-001 Parameter: WIDTH, default 4, bit width of each lane (a/x and b/y); all widths below are WIDTH.
REQ-002 Port: clk  input  1  single clock; all sequential logic on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: a  input  4  lane-A operand.
REQ-005 Port: b  input  4  lane-B operand.
REQ-006 Port: x  output  4  combinational bitwise inverse of a.
REQ-007 Port: y  output  4  combinational bitwise inverse of b.
REQ-008 Port: x_q  output  4  registered copy of x.
REQ-009 Port: y_q  output  4  registered copy of y.
REQ-010 Port: chg  output  1  one-cycle pulse, registered outputs changed this cycle.
REQ-011 Port: chg_cnt  output  8  saturating count of chg pulses since reset.

Function
REQ-012 x SHALL equal ~a bit-for-bit, purely combinational, no clock dependency; output valid within 1 ns of an input change in simulation (zero-delay model).
REQ-013 y SHALL equal ~b bit-for-bit, purely combinational, independent of a and clock.
REQ-014 x and y SHALL be unaffected by rst_n (inversion holds during reset).
REQ-015 On each rising clk edge with rst_n high, x_q <= ~a and y_q <= ~b; latency exactly 1 cycle.
REQ-016 chg SHALL be registered: high for the cycle after an edge where {~a,~b} differs from the current {x_q,y_q}; low otherwise.
REQ-017 chg_cnt SHALL increment by 1 on each edge where chg is set, saturating at 8'hFF (no wrap).
REQ-018 Simultaneous changes on a and b SHALL yield a single chg pulse and a single count.
REQ-019 X/Z on an input bit SHALL propagate as X on the corresponding x/y bit (no masking).

Reset
REQ-020 rst_n low SHALL immediately (asynchronously) force x_q=0, y_q=0, chg=0, chg_cnt=0.
REQ-021 Release of rst_n SHALL be treated as synchronous-to-clk; first capture at the first rising edge with rst_n high.
REQ-022 Reset asserted mid-operation SHALL discard pending capture; no chg pulse generated by reset itself.
REQ-023 First capture after reset SHALL compare against the reset value 0 (e.g. a=b=4'b1111 gives no chg).

Configuration
REQ-024 Macro NOT_4_REG_EN: when defined, x_q, y_q, chg and chg_cnt are implemented per REQ-015..REQ-023.
REQ-025 When NOT_4_REG_EN is undefined: x_q=x, y_q=y (combinational pass-through), chg tied 0, chg_cnt tied 0, no flops inferred; ports remain present.

Verification
REQ-026 a=0000,b=0000 -> x=1111,y=1111 within 1 ns; a=1111,b=1111 -> x=0000,y=0000.
REQ-027 Sweep a/b pairs 1010/0101, 1100/0011, 0001/1000, 0110/1001, 0101/0011 -> x=~a,y=~b each, checked 1 ns after apply; bench reports zero mismatches.
REQ-028 Exhaustive 256 a/b combinations -> x,y exact inverses; x_q,y_q match one cycle later (NOT_4_REG_EN defined).
REQ-029 rst_n low mid-run with a=1010 -> x_q,y_q,chg,chg_cnt 0 immediately while x=0101 remains; release -> x_q=0101 after first edge.
REQ-030 Toggle a each cycle for 300 cycles -> chg high each cycle, chg_cnt stops at 255.
REQ-031 Build without NOT_4_REG_EN, a=0110 -> x_q=1001 with no clock, chg=0, chg_cnt=0.
